// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package fetch_queue_pkg;

    localparam int INST_W = 16;
    localparam int PC_W   = 16;

    localparam logic [INST_W-1:0] NOP_INST = 16'h0000;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    // ST_IDLE: no request outstanding; ST_REQ: one request waiting for imem_ack.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fq_fifo.sv
// DEPTH-entry synchronous FIFO of {pc, inst} entries with flush.
// The head is read straight from storage, so a push shows up one cycle later.
module fq_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  entry_t                  push_entry,
    input  logic                    pop,
    input  logic                    flush,
    output entry_t                  head,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            // The fetch credit scheme must never let a push reach a full FIFO.
            assert (!(push && full && !flush)) else $error("fq_fifo: push while full");
        end
    end

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Fetch front-end: owns the fetch PC, runs the single-outstanding imem handshake
// and buffers returned instructions for decode, dropping wrong-path data on redirect.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              Stall,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst_out,
    output logic [PC_W-1:0]   pc_out,
    output logic [PC_W-1:0]   pc_plus_1_out
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e     state_q, state_d;
    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]  req_addr_q, req_addr_d;
    logic             discard_q, discard_d;

    logic             outstanding;
    logic             credit;
    logic             issue;
    logic             ack_take;
    logic             push;
    logic             pop;
    entry_t           push_entry;
    entry_t           head;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    assign outstanding = (state_q == ST_REQ);
    assign credit      = (fifo_count + CNT_W'(outstanding)) < CNT_W'(DEPTH);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        discard_d  = discard_q;
        issue      = 1'b0;
        ack_take   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A redirect this cycle would make fetch_pc_q stale, so wait a cycle.
                if (credit && !redirect && !rst) begin
                    issue      = 1'b1;
                    req_addr_d = fetch_pc_q;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (imem_ack) begin
                    ack_take  = 1'b1;
                    discard_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        push = ack_take && !discard_q && !redirect;

        if (redirect) begin
            fetch_pc_d = redirect_pc;
            if (outstanding && !imem_ack) begin
                discard_d = 1'b1;
            end
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + PC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= '0;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            discard_q  <= discard_d;
        end
    end

    assign push_entry = '{pc: fetch_pc_q, inst: imem_rdata};
    assign pop        = !fifo_empty && !Stall && !redirect;

    fq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect),
        .head       (head),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    assign imem_req      = issue || outstanding;
    assign imem_addr     = outstanding ? req_addr_q : (issue ? fetch_pc_q : '0);

    assign inst_valid    = !fifo_empty;
    assign inst_out      = fifo_empty ? NOP_INST : head.inst;
    assign pc_out        = fifo_empty ? '0 : head.pc;
    assign pc_plus_1_out = pc_out + PC_W'(1);

endmodule
